alu_console: RTL

Parametrised operator console for the CR16 ALU on the lab board. It assembles two P_WIDTH-bit operands and a 5-bit opcode from a narrow switch bank, one chunk per debounced LOAD button press, and drives the `alu` instance. It registers the result and status, and shows a selectable value on P_WIDTH/4 hex digits through `seven_segment_hex_mapping`. Its chain mode feeds each result back as the next A operand, so multi-step calculations need no re-keying.

---
 rtl/alu_console.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_console.sv
// Operator console: keys two operands and an opcode chunk-wise from a switch bank into the ALU and shows a selected value on hex digits.
// Latency: load lands 2 edges after I_LOAD is first sampled high, result 1 edge after the opcode write. No backpressure: presses in CAPTURE are dropped.

module seven_segment_hex_mapping (
    input  logic [3:0] I_NIBBLE,
    output logic [6:0] O_SEGMENT
);
    // Active-high segments, bit 0 = a ... bit 6 = g
    always_comb begin
        O_SEGMENT = 7'h00;
        case (I_NIBBLE)
            4'h0: O_SEGMENT = 7'h3F;
            4'h1: O_SEGMENT = 7'h06;
            4'h2: O_SEGMENT = 7'h5B;
            4'h3: O_SEGMENT = 7'h4F;
            4'h4: O_SEGMENT = 7'h66;
            4'h5: O_SEGMENT = 7'h6D;
            4'h6: O_SEGMENT = 7'h7D;
            4'h7: O_SEGMENT = 7'h07;
            4'h8: O_SEGMENT = 7'h7F;
            4'h9: O_SEGMENT = 7'h6F;
            4'hA: O_SEGMENT = 7'h77;
            4'hB: O_SEGMENT = 7'h7C;
            4'hC: O_SEGMENT = 7'h39;
            4'hD: O_SEGMENT = 7'h5E;
            4'hE: O_SEGMENT = 7'h79;
            default: O_SEGMENT = 7'h71;
        endcase
    end
endmodule

module alu #(
    parameter int P_WIDTH = 16
) (
    input  logic [P_WIDTH-1:0] I_A,
    input  logic [P_WIDTH-1:0] I_B,
    input  logic [4:0]         I_OPCODE,
    output logic [P_WIDTH-1:0] O_C,
    output logic [4:0]         O_STATUS
);
    // Status bits: [4] carry/borrow, [3] A<B unsigned, [2] signed overflow, [1] negative, [0] zero
    logic [P_WIDTH:0] sum;
    logic [P_WIDTH:0] diff;
    logic             carry;
    logic             ovf;

    always_comb begin
        sum   = {1'b0, I_A} + {1'b0, I_B};
        diff  = {1'b0, I_A} - {1'b0, I_B};
        O_C   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (I_OPCODE)
            5'h01: begin
                O_C   = sum[P_WIDTH-1:0];
                carry = sum[P_WIDTH];
                ovf   = (I_A[P_WIDTH-1] == I_B[P_WIDTH-1]) && (O_C[P_WIDTH-1] != I_A[P_WIDTH-1]);
            end
            5'h02: begin
                O_C   = diff[P_WIDTH-1:0];
                carry = diff[P_WIDTH];
                ovf   = (I_A[P_WIDTH-1] != I_B[P_WIDTH-1]) && (O_C[P_WIDTH-1] != I_A[P_WIDTH-1]);
            end
            5'h03: O_C = I_A & I_B;
            5'h04: O_C = I_A | I_B;
            5'h05: O_C = I_A ^ I_B;
            5'h06: O_C = ~I_A;
            5'h07: begin
                O_C   = {I_A[P_WIDTH-2:0], 1'b0};
                carry = I_A[P_WIDTH-1];
            end
            5'h08: begin
                O_C   = {1'b0, I_A[P_WIDTH-1:1]};
                carry = I_A[0];
            end
            5'h09: O_C = I_B;
            default: O_C = '0;
        endcase
        O_STATUS = {carry, (I_A < I_B), ovf, O_C[P_WIDTH-1], (O_C == '0)};
    end
endmodule

module alu_console #(
    parameter int P_WIDTH    = 16,
    parameter int P_IN_WIDTH = 8,
    localparam int N  = P_WIDTH / P_IN_WIDTH,
    localparam int D  = P_WIDTH / 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    input  logic [P_IN_WIDTH-1:0] I_INPUT,
    input  logic                  I_LOAD,
    input  logic                  I_CHAIN,
    input  logic [1:0]            I_SHOW,
    output logic [7*D-1:0]        O_7_SEGMENT,
    output logic [4:0]            O_STATUS_LED,
    output logic                  O_RESULT_VALID,
    output logic [1:0]            O_PHASE,
    output logic [CW-1:0]         O_CHUNK
);
    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESULT  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        chunk_q, chunk_d;
    logic [P_WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [4:0]           op_q, op_d, status_q, status_d;
    logic [2:0]           sync_q, sync_d;
    logic                 load;
    logic                 last_chunk;
    logic [P_WIDTH-1:0]   alu_c;
    logic [4:0]           alu_status;
    logic [P_WIDTH-1:0]   show_val;

    // Chunk 0 is the most significant slice of the operand
    function automatic int chunk_lsb(input logic [CW-1:0] k);
        return (N - 1 - int'(k)) * P_IN_WIDTH;
    endfunction

    assign sync_d     = {sync_q[1:0], I_LOAD};
    assign load       = sync_q[1] & ~sync_q[2];
    assign last_chunk = (int'(chunk_q) == N - 1);

    always_comb begin
        state_d  = state_q;
        chunk_d  = chunk_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        status_d = status_q;
        case (state_q)
            S_LOAD_A, S_LOAD_B: begin
                if (load) begin
                    if (state_q == S_LOAD_A) a_d[chunk_lsb(chunk_q) +: P_IN_WIDTH] = I_INPUT;
                    else                     b_d[chunk_lsb(chunk_q) +: P_IN_WIDTH] = I_INPUT;
                    chunk_d = chunk_q + 1'b1;
                    if (last_chunk) begin
                        chunk_d = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_LOAD_OP;
                    end
                end
            end
            S_LOAD_OP: begin
                if (load) begin
                    op_d    = I_INPUT[4:0];
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = alu_c;
                status_d = alu_status;
                state_d  = S_RESULT;
            end
            S_RESULT: begin
                // The press that leaves RESULT also carries the first chunk of new input
                if (load) begin
                    chunk_d = (N > 1) ? CW'(1) : '0;
                    if (I_CHAIN) begin
                        a_d                          = result_q;
                        b_d[P_WIDTH-1 -: P_IN_WIDTH] = I_INPUT;
                        state_d = (N > 1) ? S_LOAD_B : S_LOAD_OP;
                    end else begin
                        a_d[P_WIDTH-1 -: P_IN_WIDTH] = I_INPUT;
                        state_d = (N > 1) ? S_LOAD_A : S_LOAD_B;
                    end
                end
            end
            default: begin
                state_d = S_LOAD_A;
                chunk_d = '0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q  <= S_LOAD_A;
            chunk_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            status_q <= '0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            chunk_q  <= chunk_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            status_q <= status_d;
            sync_q   <= sync_d;
        end
    end

    alu #(.P_WIDTH(P_WIDTH)) u_alu (
        .I_A      (a_q),
        .I_B      (b_q),
        .I_OPCODE (op_q),
        .O_C      (alu_c),
        .O_STATUS (alu_status)
    );

    always_comb begin
        show_val = result_q;
        case (I_SHOW)
            2'd1:    show_val = a_q;
            2'd2:    show_val = b_q;
            2'd3:    show_val = {{(P_WIDTH-5){1'b0}}, op_q};
            default: show_val = result_q;
        endcase
    end

    for (genvar i = 0; i < D; i++) begin : g_digit
        seven_segment_hex_mapping u_seg (
            .I_NIBBLE  (show_val[4*i +: 4]),
            .O_SEGMENT (O_7_SEGMENT[7*i +: 7])
        );
    end

    always_comb begin
        O_PHASE = 2'd0;
        case (state_q)
            S_LOAD_B:             O_PHASE = 2'd1;
            S_LOAD_OP, S_CAPTURE: O_PHASE = 2'd2;
            S_RESULT:             O_PHASE = 2'd3;
            default:              O_PHASE = 2'd0;
        endcase
    end

    assign O_RESULT_VALID = (state_q == S_RESULT);
    assign O_STATUS_LED   = status_q;
    assign O_CHUNK        = chunk_q;
endmodule
